div_scheduler: RTL and testbench
================================

Name: div_scheduler

Overview:
- Shares one serial repeated-subtraction divider among NREQ requesters using a round-robin policy.
- Drives the divider's single data-input bus: dividend in one cycle, divisor in the next, then waits for completion.
- Returns quotient and remainder to the granted requester with a one-cycle done pulse.
- Intercepts divide-by-zero without engaging the divider, and aborts a divider that hangs past a timeout.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, operand/result width
- TIMEOUT, 300, max cycles in WAIT before abort (must exceed 2^DW)

Ports:
- clk  in  1  system clock
- clear  in  1  synchronous active-high reset
- req  in  NREQ  per-requester request level
- dividend  in  NREQ*DW  packed operands; requester i at [i*DW +: DW]
- divisor  in  NREQ*DW  packed operands, same packing
- gnt  out  NREQ  one-hot; index currently being served
- done  out  NREQ  one-cycle pulse to the served index
- quotient  out  DW  result, valid while done is high, held until next done
- remainder  out  DW  result, same timing as quotient
- div0  out  1  set with done when divisor was 0
- err  out  1  set with done when timeout abort occurred
- busy  out  1  high in every state except IDLE
- div_start  out  1  one-cycle start to the divider
- div_data  out  DW  divider data-input bus
- div_clear  out  1  divider clear; equals clear OR abort pulse
- div_done  in  1  divider completion pulse
- div_quot  in  DW  divider quotient
- div_rem  in  DW  divider remainder

Behaviour:
- Reset values: gnt, done, quotient, remainder, div0, err, busy, div_start, div_data and the WAIT counter are all 0. State is IDLE. The RR pointer is 0.
- States: IDLE, LOAD_N, LOAD_D, WAIT, RESP.
- IDLE, no req: stay in IDLE.
- IDLE, any req: pick the first asserted req at or after the pointer (wrapping), register gnt and latch that requester's operands.
  - If the latched divisor is 0, go to RESP with quotient={DW{1}}, remainder=dividend, div0=1.
  - Otherwise go to LOAD_N.
- LOAD_N: div_start=1, div_data=dividend. Go to LOAD_D.
- LOAD_D: div_start=0, div_data=divisor. Clear the counter. Go to WAIT.
- WAIT: hold div_data=divisor and increment the counter.
  - On div_done, capture div_quot/div_rem and go to RESP.
  - If the counter reaches TIMEOUT-1 without div_done, pulse div_clear for one cycle, set err=1 with quotient=remainder=0, and go to RESP.
- RESP: done[gnt]=1 for this cycle only. Set pointer = (served index + 1) mod NREQ. Clear gnt. Return to IDLE.
- Latency from the IDLE grant cycle k:
  - divide-by-zero: done at k+1
  - normal: div_start at k+1, done one cycle after div_done
- Handshake: the requester holds req and operands until its done pulse. Operands are latched in IDLE, so later changes are ignored.
  - req dropped after grant: the operation still completes and done still pulses.
  - req still high in the cycle after done: treated as a new request, eligible only under round-robin order.
- div0 and err are cleared at the next grant.
- div_done arriving outside WAIT is ignored.
- Simultaneous div_done and timeout in the same cycle: div_done wins and err stays 0.
- clear asserted mid-operation: return to reset values on the next edge. No done is issued, and div_clear is high that cycle.

Decomposition:
- Package div_sched_pkg holds the state encoding localparams (IDLE..RESP), the DIV0_QUOT all-ones constant, and the counter width function clog2(TIMEOUT).
- One sub-module, rr_arbiter (inputs req and pointer; output one-hot grant), is combinational and instantiated once.

Test Plan:
- Single requester: req[1], 100/7 -> div_start one cycle after grant, div_data 100 then 7; on div_done (q=14, r=2), done[1] pulses with quotient 14, remainder 2.
- Fairness: req=4'b1111 held, each served with 9/3 -> grant order 0,1,2,3,0. No index is served twice before the others.
- Divide-by-zero: req[2], 55/0 -> done[2] at grant+1 with quotient 8'hFF, remainder 55, div0=1. div_start is never asserted.
- Timeout: div_done tied 0, req[0] -> after 300 WAIT cycles, div_clear pulses, then done[0] with err=1 and quotient=remainder=0. busy falls afterwards.
- Reset mid-operation: clear high during WAIT -> all outputs 0 on the next edge, no done. A subsequent req[3] with 20/4 returns quotient 5, remainder 0.
- Requester drops req during WAIT: done still pulses for that index and the pointer advances.

Source files
------------

// File: rtl/div_sched_pkg.sv
// ============================================================================
// div_sched_pkg : shared state encoding, constants and helpers for div_scheduler
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package div_sched_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_N = 3'd1;
  localparam logic [2:0] ST_LOAD_D = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD_N = ST_LOAD_N,
    LOAD_D = ST_LOAD_D,
    WAIT   = ST_WAIT,
    RESP   = ST_RESP
  } state_t;

  // Wide enough for any supported DW; users take the low DW bits.
  localparam logic [63:0] DIV0_QUOT = '1;

  // Bits needed to count 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, first req at or after ptr
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/div_scheduler.sv
// ============================================================================
// div_scheduler : round-robin sharing of one serial divider among NREQ users
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 300
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] dividend,
  input  logic [NREQ*DW-1:0] divisor,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      quotient,
  output logic [DW-1:0]      remainder,
  output logic               div0,
  output logic               err,
  output logic               busy,
  output logic               div_start,
  output logic [DW-1:0]      div_data,
  output logic               div_clear,
  input  logic               div_done,
  input  logic [DW-1:0]      div_quot,
  input  logic [DW-1:0]      div_rem
);

  localparam int PW = clog2(NREQ);
  localparam int CW = clog2(TIMEOUT);

  state_t          state, state_nx;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   sel_idx;
  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic [DW-1:0]   n_sel, d_sel;
  logic [DW-1:0]   op_n, op_d;
  logic [CW-1:0]   cnt;
  logic            abort;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    n_sel   = '0;
    d_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        arb_idx = PW'(i);
        n_sel   = dividend[i*DW +: DW];
        d_sel   = divisor[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_nx = state;
    abort    = 1'b0;
    case (state)
      IDLE:   if (|req) state_nx = (d_sel == '0) ? RESP : LOAD_N;
      LOAD_N: state_nx = LOAD_D;
      LOAD_D: state_nx = WAIT;
      WAIT: begin
        // A completion in the final counted cycle takes precedence over abort.
        if (div_done) begin
          state_nx = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          abort    = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    div_start = (state == LOAD_N);
    done      = (state == RESP) ? gnt : '0;
    div_clear = clear | abort;
    div_data  = '0;
    if (state == LOAD_N)                       div_data = op_n;
    else if (state == LOAD_D || state == WAIT) div_data = op_d;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      ptr       <= '0;
      sel_idx   <= '0;
      gnt       <= '0;
      op_n      <= '0;
      op_d      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= arb_gnt;
            sel_idx <= arb_idx;
            op_n    <= n_sel;
            op_d    <= d_sel;
            div0    <= 1'b0;
            err     <= 1'b0;
            if (d_sel == '0) begin
              quotient  <= DIV0_QUOT[DW-1:0];
              remainder <= n_sel;
              div0      <= 1'b1;
            end
          end
        end
        LOAD_D: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (div_done) begin
            quotient  <= div_quot;
            remainder <= div_rem;
          end else if (abort) begin
            quotient  <= '0;
            remainder <= '0;
            err       <= 1'b1;
          end
        end
        RESP: begin
          gnt <= '0;
          ptr <= (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_scheduler.sv
// ============================================================================
// tb_div_scheduler : directed self-checking bench for div_scheduler
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_div_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 300;

  logic               clk = 1'b0;
  logic               clear;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] dividend, divisor;
  logic [NREQ-1:0]    gnt, done;
  logic [DW-1:0]      quotient, remainder;
  logic               div0, err, busy, div_start, div_clear, div_done;
  logic [DW-1:0]      div_data, div_quot, div_rem;

  int total = 0;
  int bad   = 0;

  div_scheduler #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .clear(clear), .req(req), .dividend(dividend), .divisor(divisor),
    .gnt(gnt), .done(done), .quotient(quotient), .remainder(remainder),
    .div0(div0), .err(err), .busy(busy), .div_start(div_start),
    .div_data(div_data), .div_clear(div_clear), .div_done(div_done),
    .div_quot(div_quot), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int idx, input logic [DW-1:0] n, input logic [DW-1:0] d);
    dividend[idx*DW +: DW] = n;
    divisor[idx*DW +: DW]  = d;
  endtask

  task automatic do_clear();
    clear = 1'b1; req = '0; div_done = 1'b0;
    tick(); tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; req = '0; div_done = 1'b0; div_quot = '0; div_rem = '0;
    dividend = '0; divisor = '0;
    tick(); tick();
    total++; if (gnt !== 4'b0)      begin bad++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
    total++; if (done !== 4'b0)     begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if ({busy, div_start, div0, err} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {busy, div_start, div0, err}); end
    total++; if ({quotient, remainder, div_data} !== 24'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {quotient, remainder, div_data}); end
    total++; if (div_clear !== 1'b1) begin bad++; $display("FAIL reset_div_clear got=%b exp=1", div_clear); end
    clear = 1'b0;
  endtask

  task automatic test_single();
    set_ops(1, 8'd100, 8'd7);
    req = 4'b0010;
    tick();
    total++; if (gnt !== 4'b0010)   begin bad++; $display("FAIL single_gnt got=%b exp=0010", gnt); end
    total++; if (div_start !== 1'b1 || div_data !== 8'd100) begin bad++; $display("FAIL single_load_n got start=%b data=%0d exp 1/100", div_start, div_data); end
    // A stray completion outside WAIT must be ignored.
    div_done = 1'b1; div_quot = 8'd99; div_rem = 8'd99;
    tick();
    div_done = 1'b0;
    total++; if (div_start !== 1'b0 || div_data !== 8'd7 || done !== 4'b0) begin bad++; $display("FAIL single_load_d got start=%b data=%0d done=%b exp 0/7/0000", div_start, div_data, done); end
    tick();
    total++; if (div_data !== 8'd7 || busy !== 1'b1) begin bad++; $display("FAIL single_wait got data=%0d busy=%b exp 7/1", div_data, busy); end
    div_done = 1'b1; div_quot = 8'd14; div_rem = 8'd2;
    tick();
    div_done = 1'b0; req = '0;
    total++; if (done !== 4'b0010)  begin bad++; $display("FAIL single_done got=%b exp=0010", done); end
    total++; if (quotient !== 8'd14 || remainder !== 8'd2) begin bad++; $display("FAIL single_result got=%0d/%0d exp=14/2", quotient, remainder); end
    tick();
    total++; if (done !== 4'b0 || gnt !== 4'b0 || busy !== 1'b0 || quotient !== 8'd14) begin bad++; $display("FAIL single_after got done=%b gnt=%b busy=%b q=%0d exp 0/0/0/14", done, gnt, busy, quotient); end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] exp;
    do_clear();
    for (int i = 0; i < NREQ; i++) set_ops(i, 8'd9, 8'd3);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      tick();
      total++; if (gnt !== exp) begin bad++; $display("FAIL fair_gnt%0d got=%b exp=%b", k, gnt, exp); end
      tick(); tick();
      div_done = 1'b1; div_quot = 8'd3; div_rem = 8'd0;
      tick();
      div_done = 1'b0;
      total++; if (done !== exp || quotient !== 8'd3) begin bad++; $display("FAIL fair_done%0d got=%b q=%0d exp=%b q=3", k, done, quotient, exp); end
      tick();
    end
    req = '0;
    tick();
  endtask

  task automatic test_div0();
    do_clear();
    set_ops(2, 8'd55, 8'd0);
    req = 4'b0100;
    tick();
    req = '0;
    total++; if (done !== 4'b0100) begin bad++; $display("FAIL div0_done got=%b exp=0100", done); end
    total++; if (quotient !== 8'hFF || remainder !== 8'd55 || div0 !== 1'b1) begin bad++; $display("FAIL div0_result got q=%h r=%0d div0=%b exp ff/55/1", quotient, remainder, div0); end
    total++; if (div_start !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL div0_nostart got start=%b err=%b exp 0/0", div_start, err); end
    tick();
    total++; if (done !== 4'b0 || busy !== 1'b0 || div_start !== 1'b0) begin bad++; $display("FAIL div0_after got done=%b busy=%b start=%b exp 0/0/0", done, busy, div_start); end
  endtask

  task automatic test_timeout();
    int n;
    do_clear();
    set_ops(0, 8'd50, 8'd5);
    req = 4'b0001;
    tick(); tick(); tick();
    n = 0;
    for (int c = 1; c <= TO + 100; c++) begin
      if (div_clear) begin n = c; break; end
      tick();
    end
    total++; if (n !== TO) begin bad++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TO); end
    req = '0;
    tick();
    total++; if (done !== 4'b0001 || err !== 1'b1 || div_clear !== 1'b0) begin bad++; $display("FAIL timeout_done got done=%b err=%b clr=%b exp 0001/1/0", done, err, div_clear); end
    total++; if (quotient !== 8'd0 || remainder !== 8'd0) begin bad++; $display("FAIL timeout_result got=%0d/%0d exp=0/0", quotient, remainder); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b exp=0", busy); end
  endtask

  task automatic test_done_vs_timeout();
    do_clear();
    set_ops(1, 8'd15, 8'd2);
    req = 4'b0010;
    tick(); tick(); tick();
    for (int c = 1; c < TO; c++) tick();
    div_done = 1'b1; div_quot = 8'd7; div_rem = 8'd1;
    #1;
    total++; if (div_clear !== 1'b0) begin bad++; $display("FAIL race_clear got=%b exp=0", div_clear); end
    tick();
    div_done = 1'b0; req = '0;
    total++; if (done !== 4'b0010 || err !== 1'b0 || quotient !== 8'd7 || remainder !== 8'd1) begin bad++; $display("FAIL race_done got done=%b err=%b q=%0d r=%0d exp 0010/0/7/1", done, err, quotient, remainder); end
    tick();
  endtask

  task automatic test_clear_mid();
    do_clear();
    set_ops(1, 8'd10, 8'd2);
    req = 4'b0010;
    tick(); tick(); tick(); tick();
    clear = 1'b1;
    #1;
    total++; if (div_clear !== 1'b1) begin bad++; $display("FAIL clrmid_divclr got=%b exp=1", div_clear); end
    tick();
    clear = 1'b0;
    total++; if (gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || div_data !== 8'd0) begin bad++; $display("FAIL clrmid_state got gnt=%b done=%b busy=%b data=%0d exp all 0", gnt, done, busy, div_data); end
    set_ops(3, 8'd20, 8'd4);
    req = 4'b1000;
    tick();
    total++; if (gnt !== 4'b1000 || div_data !== 8'd20) begin bad++; $display("FAIL clrmid_gnt got gnt=%b data=%0d exp 1000/20", gnt, div_data); end
    tick(); tick();
    div_done = 1'b1; div_quot = 8'd5; div_rem = 8'd0;
    tick();
    div_done = 1'b0; req = '0;
    total++; if (done !== 4'b1000 || quotient !== 8'd5 || remainder !== 8'd0) begin bad++; $display("FAIL clrmid_result got done=%b q=%0d r=%0d exp 1000/5/0", done, quotient, remainder); end
    tick();
  endtask

  task automatic test_drop_req();
    do_clear();
    set_ops(0, 8'd30, 8'd4);
    req = 4'b0001;
    tick(); tick(); tick();
    req = '0;
    set_ops(0, 8'd77, 8'd9);
    tick();
    total++; if (div_data !== 8'd4) begin bad++; $display("FAIL drop_latched got=%0d exp=4", div_data); end
    div_done = 1'b1; div_quot = 8'd7; div_rem = 8'd2;
    tick();
    div_done = 1'b0;
    total++; if (done !== 4'b0001 || quotient !== 8'd7 || remainder !== 8'd2) begin bad++; $display("FAIL drop_done got done=%b q=%0d r=%0d exp 0001/7/2", done, quotient, remainder); end
    tick();
    set_ops(1, 8'd8, 8'd2);
    req = 4'b0011;
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL drop_ptr got=%b exp=0010", gnt); end
    do_clear();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_div0();
    test_timeout();
    test_done_vs_timeout();
    test_clear_mid();
    test_drop_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
